// File: rtl/tempsens_meas_sequencer.sv
// Ring-oscillator temperature sensor measurement sequencer.
// Enables the sensor, lets it settle, counts sensor pulses over a fixed
// window, subtracts a serially loaded calibration offset and publishes the
// result with a one-cycle valid strobe.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | sensor off, waiting for START or AUTO
//   S_SETTLE | sensor on, SETTLE_CYC cycles of settling, counter cleared
//   S_COUNT  | sensor on, WINDOW_CYC cycles counting synchronized pulses
//   S_CALC   | one cycle: raw or calibrated result loaded into RESULT
module tempsens_meas_sequencer #(
  parameter int CNT_W      = 12,
  parameter int SETTLE_CYC = 16,
  parameter int WINDOW_CYC = 1024
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic             AUTO,
  input  logic             RAW,
  input  logic             CAL_CLK,
  input  logic             CAL_DAT,
  input  logic             CAL_ENA,
  input  logic             SENS_PULSE,
  output logic             SENS_EN,
  output logic             BUSY,
  output logic [CNT_W-1:0] RESULT,
  output logic             RESULT_VLD,
  output logic [CNT_W-1:0] CAL_WORD
);

  localparam int MAX_CYC = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int BW      = $clog2(CNT_W + 2);

  localparam logic [TW-1:0]    SETTLE_LD = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0]    WINDOW_LD = TW'(WINDOW_CYC - 1);
  localparam logic [BW-1:0]    BIT_FULL  = BW'(CNT_W);
  localparam logic [BW-1:0]    BIT_SAT   = BW'(CNT_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_CALC} state_t;

  // synchronizer bit order: 0 = CAL_CLK, 1 = CAL_DAT, 2 = CAL_ENA, 3 = SENS_PULSE
  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic             r_prev_cal_clk;
  logic             r_prev_cal_ena;
  logic             r_prev_pulse;

  logic [CNT_W-1:0] r_shadow;
  logic [BW-1:0]    r_bitcnt;
  logic [CNT_W-1:0] r_cal_word;

  state_t           r_state;
  logic [TW-1:0]    r_timer;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_result;
  logic             r_vld;
  logic             r_sens_en;
  logic             r_busy;

  logic             w_cal_clk_rise;
  logic             w_cal_ena_fall;
  logic             w_pulse_rise;
  logic             w_cal_load;
  logic [CNT_W-1:0] w_cal_eff;
  logic [CNT_W-1:0] w_diff;
  logic [CNT_W-1:0] w_calib;

  assign w_cal_clk_rise = r_sync2[0] & ~r_prev_cal_clk;
  assign w_cal_ena_fall = ~r_sync2[2] & r_prev_cal_ena;
  assign w_pulse_rise   = r_sync2[3] & ~r_prev_pulse;

  // A frame completing in the CALC cycle is already visible to that CALC.
  assign w_cal_load = w_cal_ena_fall && (r_bitcnt == BIT_FULL);
  assign w_cal_eff  = w_cal_load ? r_shadow : r_cal_word;
  assign w_diff     = r_count - w_cal_eff;
  assign w_calib    = (r_count >= w_cal_eff) ? w_diff : '0;

  assign SENS_EN    = r_sens_en;
  assign BUSY       = r_busy;
  assign RESULT     = r_result;
  assign RESULT_VLD = r_vld;
  assign CAL_WORD   = r_cal_word;

  // Two-flop synchronizers plus previous-value flops for edge detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1        <= '0;
      r_sync2        <= '0;
      r_prev_cal_clk <= 1'b0;
      r_prev_cal_ena <= 1'b0;
      r_prev_pulse   <= 1'b0;
    end else begin
      r_sync1        <= {SENS_PULSE, CAL_ENA, CAL_DAT, CAL_CLK};
      r_sync2        <= r_sync1;
      r_prev_cal_clk <= r_sync2[0];
      r_prev_cal_ena <= r_sync2[2];
      r_prev_pulse   <= r_sync2[3];
    end
  end

  // Calibration shift-in; the word is committed only for an exact-length frame.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_shadow   <= '0;
      r_bitcnt   <= '0;
      r_cal_word <= '0;
    end else if (!r_sync2[2]) begin
      r_shadow <= '0;
      r_bitcnt <= '0;
      if (w_cal_load) r_cal_word <= r_shadow;
    end else if (w_cal_clk_rise) begin
      r_shadow <= {r_shadow[CNT_W-2:0], r_sync2[1]};
      if (r_bitcnt != BIT_SAT) r_bitcnt <= r_bitcnt + 1'b1;
    end
  end

  // Measurement sequencer with registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_count   <= '0;
      r_result  <= '0;
      r_vld     <= 1'b0;
      r_sens_en <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START || AUTO) begin
            r_state   <= S_SETTLE;
            r_timer   <= SETTLE_LD;
            r_count   <= '0;
            r_sens_en <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (r_timer == '0) begin
            r_state <= S_COUNT;
            r_timer <= WINDOW_LD;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_COUNT: begin
          if (w_pulse_rise && (r_count != CNT_MAX)) r_count <= r_count + 1'b1;
          if (r_timer == '0) begin
            r_state   <= S_CALC;
            r_sens_en <= 1'b0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_CALC: begin
          r_result <= RAW ? r_count : w_calib;
          r_vld    <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tempsens_meas_sequencer.sv
// Self-checking bench for tempsens_meas_sequencer: a default 12-bit instance
// and an 8-bit instance share all inputs; expected results come from a
// record of every sensor rising edge driven and the calibration frames sent.
module tb_tempsens_meas_sequencer;

  localparam int S   = 16;
  localparam int W   = 1024;
  localparam int TOT = S + W + 2;

  logic        CLK = 1'b0;
  logic        RESET_N, START, AUTO, RAW, CAL_CLK, CAL_DAT, CAL_ENA, SENS_PULSE;
  logic        SENS_EN, BUSY, RESULT_VLD;
  logic [11:0] RESULT, CAL_WORD;
  logic        SENS_EN8, BUSY8, RESULT_VLD8;
  logic [7:0]  RESULT8, CAL_WORD8;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cal_model = 0;
  int p_mode  = 0;   // 0 off, 1 fixed half-period p_half, 2 random phases
  int p_half  = 4;
  int rise_q[$];

  tempsens_meas_sequencer dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .AUTO(AUTO), .RAW(RAW),
    .CAL_CLK(CAL_CLK), .CAL_DAT(CAL_DAT), .CAL_ENA(CAL_ENA), .SENS_PULSE(SENS_PULSE),
    .SENS_EN(SENS_EN), .BUSY(BUSY), .RESULT(RESULT), .RESULT_VLD(RESULT_VLD),
    .CAL_WORD(CAL_WORD)
  );

  tempsens_meas_sequencer #(.CNT_W(8)) dut8 (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .AUTO(AUTO), .RAW(RAW),
    .CAL_CLK(CAL_CLK), .CAL_DAT(CAL_DAT), .CAL_ENA(CAL_ENA), .SENS_PULSE(SENS_PULSE),
    .SENS_EN(SENS_EN8), .BUSY(BUSY8), .RESULT(RESULT8), .RESULT_VLD(RESULT_VLD8),
    .CAL_WORD(CAL_WORD8)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Sensor oscillator: rises recorded with the cycle number they were driven in.
  initial begin
    int left;
    left = 0;
    SENS_PULSE = 1'b0;
    forever begin
      @(negedge CLK);
      if (p_mode == 0) begin
        SENS_PULSE = 1'b0;
        left = 0;
      end else begin
        if (left > 0) left--;
        if (left == 0) begin
          SENS_PULSE = ~SENS_PULSE;
          if (SENS_PULSE) rise_q.push_back(cyc);
          left = (p_mode == 1) ? p_half : int'($urandom_range(2, 6));
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic [31:0] obs, input int exp);
    logic ok;
    n_tests++;
    ok = !$isunknown(obs) && (int'(obs) <= exp + 1) && (int'(obs) >= exp - 1);
    assert (ok === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d (+/-1)", tag, obs, exp);
    end
  endtask

  function automatic int count_rises(input int lo, input int hi);
    int c = 0;
    foreach (rise_q[i]) if (rise_q[i] >= lo && rise_q[i] <= hi) c++;
    return c;
  endfunction

  task automatic send_cal(input int nbits, input logic [15:0] val);
    CAL_ENA = 1'b1;
    repeat (3) @(negedge CLK);
    for (int i = nbits - 1; i >= 0; i--) begin
      CAL_DAT = val[i];
      repeat (3) @(negedge CLK);
      CAL_CLK = 1'b1;
      repeat (3) @(negedge CLK);
      CAL_CLK = 1'b0;
    end
    repeat (3) @(negedge CLK);
    CAL_ENA = 1'b0;
    CAL_DAT = 1'b0;
    if (nbits == 12) cal_model = int'(val[11:0]);
    repeat (6) @(negedge CLK);
  endtask

  // Issues a one-cycle START from an IDLE negedge; returns in cycle 1.
  task automatic start_meas(output int t0);
    chk("idle_before_start", BUSY, 0);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    t0 = cyc;
  endtask

  // Entered at the negedge of cycle 1 (t0 = its cycle number); leaves at the
  // negedge of the RESULT_VLD cycle.
  task automatic run_meas(input int t0, input bit raw, input int auto_drop_at,
                          input bit probe_start, output int vld_cyc);
    int bad_en = 0, bad_busy = 0, bad_vld = 0, bad8 = 0;
    int cnt, c12, e;
    for (int n = 1; n <= TOT; n++) begin
      if (n == 1) RAW = ~raw;
      if (n == S + W) RAW = raw;
      if (probe_start && n == 500) START = 1'b1;
      if (probe_start && n == 501) START = 1'b0;
      if (n == auto_drop_at) AUTO = 1'b0;
      if (bad_en == 0 && SENS_EN !== (n <= S + W)) bad_en = n;
      if (bad_busy == 0 && BUSY !== (n <= S + W + 1)) bad_busy = n;
      if (bad_vld == 0 && RESULT_VLD !== (n == TOT)) bad_vld = n;
      if (bad8 == 0 && ({SENS_EN8, BUSY8, RESULT_VLD8} !==
                        {n <= S + W, n <= S + W + 1, n == TOT})) bad8 = n;
      if (n != TOT) @(negedge CLK);
    end
    vld_cyc = cyc;
    chk("sens_en_first_bad_cycle", bad_en, 0);
    chk("busy_first_bad_cycle", bad_busy, 0);
    chk("vld_first_bad_cycle", bad_vld, 0);
    chk("dut8_ctrl_first_bad_cycle", bad8, 0);
    cnt = count_rises(t0 + S - 1, t0 + S + W - 2);
    c12 = (cnt > 4095) ? 4095 : cnt;
    e   = raw ? c12 : ((c12 >= cal_model) ? c12 - cal_model : 0);
    chk_tol(raw ? "result_raw" : "result_cal", RESULT, e);
    chk_tol("result8_sat", RESULT8, (cnt > 255) ? 255 : cnt);
  endtask

  initial begin
    int t0, v1, v2, bad, nb;
    logic [15:0] rv;
    RESET_N = 1'b0; START = 1'b0; AUTO = 1'b0; RAW = 1'b1;
    CAL_CLK = 1'b0; CAL_DAT = 1'b0; CAL_ENA = 1'b0;

    // reset held while START/AUTO toggle
    bad = 0;
    for (int i = 1; i <= 20; i++) begin
      START = 1'($urandom_range(0, 1));
      AUTO  = 1'($urandom_range(0, 1));
      @(negedge CLK);
      if (bad == 0 && ({SENS_EN, BUSY, RESULT_VLD, RESULT, CAL_WORD,
                        SENS_EN8, BUSY8, RESULT_VLD8, RESULT8, CAL_WORD8} !== '0)) bad = i;
    end
    chk("reset_hold_first_bad_cycle", bad, 0);
    chk("reset_result", RESULT, 0);
    chk("reset_cal_word", CAL_WORD, 0);
    START = 1'b0; AUTO = 1'b0;
    RESET_N = 1'b1;
    repeat (5) @(negedge CLK);
    chk("idle_after_reset_busy", BUSY, 0);
    chk("idle_after_reset_sens_en", SENS_EN, 0);

    // raw count, period 8, with an ignored START during BUSY
    p_mode = 1; p_half = 4;
    repeat (20) @(negedge CLK);
    start_meas(t0);
    run_meas(t0, 1'b1, -1, 1'b1, v1);
    chk("vld_latency", v1 - t0, TOT - 1);
    @(negedge CLK);
    chk("no_requeued_start", BUSY, 0);

    // calibrated
    send_cal(12, 16'h050);
    chk("cal_word_050", CAL_WORD, 12'h050);
    start_meas(t0);
    run_meas(t0, 1'b0, -1, 1'b0, v1);
    @(negedge CLK);

    // clamp, then short and long frames leave the word alone
    send_cal(12, 16'h0C8);
    chk("cal_word_0c8", CAL_WORD, 12'h0C8);
    start_meas(t0);
    run_meas(t0, 1'b0, -1, 1'b0, v1);
    chk("result_clamped", RESULT, 0);
    @(negedge CLK);
    send_cal(9, 16'h1AB);
    chk("cal_word_after_9bit", CAL_WORD, 12'h0C8);
    send_cal(13, 16'h1FFF);
    chk("cal_word_after_13bit", CAL_WORD, 12'h0C8);
    chk("cal_word8_untouched", CAL_WORD8, 0);

    // saturation in the 8-bit instance, period 4
    p_half = 2;
    repeat (10) @(negedge CLK);
    start_meas(t0);
    run_meas(t0, 1'b1, -1, 1'b0, v1);
    chk("result8_is_255", RESULT8, 255);
    @(negedge CLK);

    // AUTO, period 16; AUTO dropped during COUNT of the second run
    p_half = 8;
    repeat (10) @(negedge CLK);
    AUTO = 1'b1;
    @(negedge CLK);
    t0 = cyc;
    run_meas(t0, 1'b1, -1, 1'b0, v1);
    @(negedge CLK);
    t0 = cyc;
    run_meas(t0, 1'b1, 600, 1'b0, v2);
    chk("auto_vld_period", v2 - v1, TOT);
    bad = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge CLK);
      if (bad == 0 && (BUSY !== 1'b0 || SENS_EN !== 1'b0)) bad = i;
    end
    chk("auto_off_stays_idle", bad, 0);

    // random pulses, random frames of random length
    p_mode = 2;
    for (int k = 0; k < 3; k++) begin
      nb = int'($urandom_range(10, 13));
      rv = 16'($urandom_range(0, 16'hFFFF));
      send_cal(nb, rv);
      chk("cal_word_rand_frame", CAL_WORD, 12'(cal_model));
    end
    send_cal(12, 16'($urandom_range(0, 150)));
    start_meas(t0);
    run_meas(t0, 1'b0, -1, 1'b0, v1);
    @(negedge CLK);

    // frame loaded while a measurement is running
    start_meas(t0);
    fork
      run_meas(t0, 1'($urandom_range(0, 1)), -1, 1'b0, v1);
      begin
        repeat (200) @(negedge CLK);
        send_cal(12, 16'($urandom_range(0, 150)));
      end
    join
    chk("cal_word_mid_meas", CAL_WORD, 12'(cal_model));
    @(negedge CLK);

    // reset in the middle of COUNT
    start_meas(t0);
    repeat (300) @(negedge CLK);
    #1 RESET_N = 1'b0;
    #1;
    chk("async_reset_sens_en", SENS_EN, 0);
    chk("async_reset_busy", BUSY, 0);
    chk("async_reset_cal_word", CAL_WORD, 0);
    cal_model = 0;
    @(negedge CLK);
    RESET_N = 1'b1;
    bad = 0;
    for (int i = 1; i <= 1100; i++) begin
      @(negedge CLK);
      if (bad == 0 && (RESULT_VLD !== 1'b0 || BUSY !== 1'b0)) bad = i;
    end
    chk("no_vld_after_reset", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
